// File: rtl/antirrebote_pkg.sv
// ============================================================================
// antirrebote_pkg : shared FSM encoding and timing defaults for the debounce
//                   scheduler.
// Rev 1.0
// ============================================================================
`default_nettype none

package antirrebote_pkg;

    localparam int unsigned c_ESTADO_W = 2;

    localparam logic [c_ESTADO_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ESTADO_W-1:0] c_ST_GRANT = 2'd1;
    localparam logic [c_ESTADO_W-1:0] c_ST_LOCK  = 2'd2;

    // 300 ms lockout at a 50 MHz clock
    localparam int unsigned c_T_BLOQUEO_50MHZ = 15_000_000;

endpackage

`default_nettype wire

// File: rtl/antirrebote_multi_ctrl_sincroniza_flanco.sv
// ============================================================================
// sincroniza_flanco : 2-flop synchronizer plus rising-edge detector for one
//                     raw button input (falling-edge registers).
// Rev 1.0
// ============================================================================
`default_nettype none

module sincroniza_flanco (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_boton,
    output logic o_subida
);

    logic r_sinc1;
    logic r_sinc2;
    logic r_previo;

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sinc1  <= 1'b0;
            r_sinc2  <= 1'b0;
            r_previo <= 1'b0;
        end else begin
            r_sinc1  <= i_boton;
            r_sinc2  <= r_sinc1;
            r_previo <= r_sinc2;
        end
    end

    assign o_subida = r_sinc2 & ~r_previo;

endmodule

`default_nettype wire

// File: rtl/antirrebote_multi_ctrl.sv
// ============================================================================
// antirrebote_multi_ctrl : round-robin debounce scheduler; N buttons share one
//                          lockout timer, one clean pulse per grant.
// Rev 1.0
// ============================================================================
`default_nettype none

module antirrebote_multi_ctrl
    import antirrebote_pkg::*;
#(
    parameter int          N_BOTONES = 4,
    parameter int unsigned T_BLOQUEO = c_T_BLOQUEO_50MHZ,
    parameter int          CNT_W     = 24,
    parameter int          ID_W      = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 enable,
    input  logic [N_BOTONES-1:0] boton_in,
    output logic [N_BOTONES-1:0] boton_pulso,
    output logic                 actCuenta,
    output logic                 ocupado,
    output logic [ID_W-1:0]      id_activo,
    output logic [N_BOTONES-1:0] pendiente
);

    localparam logic [CNT_W-1:0] c_CNT_FIN = CNT_W'(T_BLOQUEO - 1);

    logic [N_BOTONES-1:0]  w_subida;
    logic [N_BOTONES-1:0]  r_pend;
    logic [N_BOTONES-1:0]  w_pend_sig;
    logic [c_ESTADO_W-1:0] r_estado;
    logic [c_ESTADO_W-1:0] w_estado_sig;
    logic [CNT_W-1:0]      r_cnt;
    logic [ID_W-1:0]       r_id;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       w_ganador;
    logic                  w_hay;
    logic                  w_conceder;
    int                    w_idx;
    logic [N_BOTONES-1:0]  r_pulso;
    logic [N_BOTONES-1:0]  w_pulso_sig;
    logic                  r_act;
    logic                  w_act_sig;
    logic                  r_ocupado;
    logic                  w_ocupado_sig;

    generate
        for (genvar g = 0; g < N_BOTONES; g++) begin : g_canal
            sincroniza_flanco u_sinc (
                .Clk      (Clk),
                .Rst_n    (Rst_n),
                .i_boton  (boton_in[g]),
                .o_subida (w_subida[g])
            );
        end
    endgenerate

    // Round-robin search starting at the channel after the last grant
    always_comb begin
        w_hay     = 1'b0;
        w_ganador = '0;
        w_idx     = 0;
        for (int k = 0; k < N_BOTONES; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_BOTONES) begin
                w_idx = w_idx - N_BOTONES;
            end
            if (!w_hay && r_pend[w_idx[ID_W-1:0]]) begin
                w_hay     = 1'b1;
                w_ganador = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_conceder = (r_estado == c_ST_IDLE) && enable && w_hay;

    // Rises on the channel being served are bounce; the grant clear beats a same-cycle rise
    always_comb begin
        w_pend_sig = '0;
        for (int i = 0; i < N_BOTONES; i++) begin
            w_pend_sig[i] = (r_pend[i]
                             | (w_subida[i] & ~((r_estado != c_ST_IDLE) && (r_id == ID_W'(i)))))
                            & ~(w_conceder && (w_ganador == ID_W'(i)));
        end
    end

    always_comb begin
        w_estado_sig = c_ST_IDLE;
        case (r_estado)
            c_ST_IDLE:  w_estado_sig = w_conceder ? c_ST_GRANT : c_ST_IDLE;
            c_ST_GRANT: w_estado_sig = c_ST_LOCK;
            c_ST_LOCK:  w_estado_sig = (r_cnt == c_CNT_FIN) ? c_ST_IDLE : c_ST_LOCK;
            default:    w_estado_sig = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_pulso_sig = '0;
        if (w_estado_sig == c_ST_GRANT) begin
            w_pulso_sig[w_ganador] = 1'b1;
        end
        w_act_sig     = (w_estado_sig == c_ST_LOCK);
        w_ocupado_sig = (w_estado_sig != c_ST_IDLE);
    end

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_estado  <= c_ST_IDLE;
            r_pulso   <= '0;
            r_act     <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_estado  <= w_estado_sig;
            r_pulso   <= w_pulso_sig;
            r_act     <= w_act_sig;
            r_ocupado <= w_ocupado_sig;
        end
    end

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pend <= '0;
            r_cnt  <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else begin
            r_pend <= w_pend_sig;
            if (r_estado == c_ST_LOCK) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_conceder) begin
                r_id  <= w_ganador;
                r_ptr <= (w_ganador == ID_W'(N_BOTONES - 1)) ? '0 : w_ganador + ID_W'(1);
            end
        end
    end

    assign boton_pulso = r_pulso;
    assign actCuenta   = r_act;
    assign ocupado     = r_ocupado;
    assign id_activo   = r_id;
    assign pendiente   = r_pend;

endmodule

`default_nettype wire
